// File: rtl/irq_seq_if.sv
// Interrupt sequencer bus: raw requests and CSR/pipeline controls in,
// take/return pulses and pipeline controls out.
interface irq_seq_if #(
  parameter int CNT_W = 16
);
  logic             dma_irq;
  logic             wdt_irq;
  logic             mie;
  logic             meie;
  logic             mtie;
  logic             stall;
  logic             wfi_in;
  logic             mret_in;
  logic             meip_en;
  logic             mtip_en;
  logic             meip_end;
  logic             mtip_end;
  logic             flush;
  logic             wfi_halt;
  logic             in_handler;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output dma_irq, wdt_irq, mie, meie, mtie, stall, wfi_in, mret_in,
    input  meip_en, mtip_en, meip_end, mtip_end, flush, wfi_halt, in_handler, taken_cnt
  );

  modport slave (
    input  dma_irq, wdt_irq, mie, meie, mtie, stall, wfi_in, mret_in,
    output meip_en, mtip_en, meip_end, mtip_end, flush, wfi_halt, in_handler, taken_cnt
  );
endinterface

// File: rtl/irq_sequencer.sv
// Machine-mode interrupt sequencer: synchronises DMA/WDT requests, takes one
// interrupt at a time (no nesting) and drives take/return pulses, flush and WFI halt.
module irq_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit EXT_FIRST   = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic      clk,
  input  logic      rst,
  irq_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_HANDLER = 2'd2,
    S_RETURN  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] dsync_q, wsync_q;
  logic                   src_ext_q, src_ext_d;
  logic                   wfi_q, wfi_d;
  logic                   cnt_inc;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   meip_en_q, mtip_en_q, meip_end_q, mtip_end_q, flush_q, in_handler_q;
  logic                   meip_en_d, mtip_en_d, meip_end_d, mtip_end_d, flush_d, in_handler_d;
  logic                   pend_e, pend_t, pend, take_ok;

  assign pend_e  = dsync_q[SYNC_STAGES-1] & bus.meie;
  assign pend_t  = wsync_q[SYNC_STAGES-1] & bus.mtie;
  assign pend    = pend_e | pend_t;
  assign take_ok = bus.mie & pend & ~bus.stall;

  // Request synchronisers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsync_q <= {SYNC_STAGES{1'b0}};
      wsync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      dsync_q[0] <= bus.dma_irq;
      wsync_q[0] <= bus.wdt_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dsync_q[i] <= dsync_q[i-1];
        wsync_q[i] <= wsync_q[i-1];
      end
    end
  end

  // Next-state, source latch, WFI and counter logic
  always_comb begin
    state_d   = state_q;
    src_ext_d = src_ext_q;
    wfi_d     = wfi_q;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take_ok) begin
          state_d   = S_TAKE;
          src_ext_d = pend_e & (EXT_FIRST | ~pend_t);
        end else begin
          state_d = S_IDLE;
        end
        if (bus.wfi_in & ~bus.stall & ~(bus.mie & pend)) begin
          wfi_d = 1'b1;
        end else begin
          wfi_d = wfi_q;
        end
      end
      S_TAKE: begin
        if (!bus.stall) begin
          state_d = S_HANDLER;
          cnt_inc = 1'b1;
        end else begin
          state_d = S_TAKE;
        end
      end
      S_HANDLER: begin
        if (bus.mret_in & ~bus.stall) begin
          state_d = S_RETURN;
        end else begin
          state_d = S_HANDLER;
        end
      end
      S_RETURN: begin
        if (!bus.stall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RETURN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A pending request wakes the core even when MIE keeps it from being taken
    if (pend || (state_d == S_TAKE)) begin
      wfi_d = 1'b0;
    end else begin
      wfi_d = wfi_d;
    end
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from next state so the registered outputs track state_q
  always_comb begin
    meip_en_d    = (state_d == S_TAKE)   &  src_ext_d;
    mtip_en_d    = (state_d == S_TAKE)   & ~src_ext_d;
    meip_end_d   = (state_d == S_RETURN) &  src_ext_d;
    mtip_end_d   = (state_d == S_RETURN) & ~src_ext_d;
    flush_d      = (state_d == S_TAKE) | (state_d == S_RETURN);
    in_handler_d = (state_d != S_IDLE);
  end

  // State, source, WFI, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_ext_q    <= 1'b0;
      wfi_q        <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      meip_en_q    <= 1'b0;
      mtip_en_q    <= 1'b0;
      meip_end_q   <= 1'b0;
      mtip_end_q   <= 1'b0;
      flush_q      <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_ext_q    <= src_ext_d;
      wfi_q        <= wfi_d;
      cnt_q        <= cnt_d;
      meip_en_q    <= meip_en_d;
      mtip_en_q    <= mtip_en_d;
      meip_end_q   <= meip_end_d;
      mtip_end_q   <= mtip_end_d;
      flush_q      <= flush_d;
      in_handler_q <= in_handler_d;
    end
  end

  assign bus.meip_en    = meip_en_q;
  assign bus.mtip_en    = mtip_en_q;
  assign bus.meip_end   = meip_end_q;
  assign bus.mtip_end   = mtip_end_q;
  assign bus.flush      = flush_q;
  assign bus.wfi_halt   = wfi_q;
  assign bus.in_handler = in_handler_q;
  assign bus.taken_cnt  = cnt_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: expected take/return pulses are queued
// as stimulus is driven and popped by a monitor whenever a pulse appears.
module tb_irq_sequencer;

  localparam logic [3:0] E_EN  = 4'b1000;
  localparam logic [3:0] T_EN  = 4'b0100;
  localparam logic [3:0] E_END = 4'b0010;
  localparam logic [3:0] T_END = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  exp_small = 2'd0;

  irq_seq_if #(.CNT_W(16)) bus ();
  irq_seq_if #(.CNT_W(2))  bus2 ();

  irq_sequencer #(.SYNC_STAGES(2), .EXT_FIRST(1'b1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  irq_sequencer #(.SYNC_STAGES(2), .EXT_FIRST(1'b1), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  assign bus2.dma_irq = bus.dma_irq;
  assign bus2.wdt_irq = bus.wdt_irq;
  assign bus2.mie     = bus.mie;
  assign bus2.meie    = bus.meie;
  assign bus2.mtie    = bus.mtie;
  assign bus2.stall   = bus.stall;
  assign bus2.wfi_in  = bus.wfi_in;
  assign bus2.mret_in = bus.mret_in;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every pulse cycle must match the next queued expectation
  always @(negedge clk) begin
    logic [3:0] pulse;
    pulse = {bus.meip_en, bus.mtip_en, bus.meip_end, bus.mtip_end};
    if (pulse != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {28'd0, pulse}, 32'd0);
      end else begin
        check_eq("pulse", {28'd0, pulse}, {28'd0, exp_q.pop_front()});
      end
      check_eq("pulse_flush", {31'd0, bus.flush}, 32'd1);
      check_eq("pulse_in_handler", {31'd0, bus.in_handler}, 32'd1);
    end
  end

  task automatic take_and_return(input bit ext);
    exp_q.push_back(ext ? E_EN : T_EN);
    if (ext) bus.dma_irq = 1'b1; else bus.wdt_irq = 1'b1;
    repeat (4) tick();
    bus.dma_irq = 1'b0;
    bus.wdt_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(ext ? E_END : T_END);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    tick();
    exp_cnt++;
    if (exp_small != 2'd3) exp_small++;
  endtask

  initial begin
    bus.dma_irq = 1'b0; bus.wdt_irq = 1'b0; bus.mie = 1'b0; bus.meie = 1'b0;
    bus.mtie = 1'b0; bus.stall = 1'b0; bus.wfi_in = 1'b0; bus.mret_in = 1'b0;
    repeat (2) tick();
    check_eq("rst_outputs", {25'd0, bus.meip_en, bus.mtip_en, bus.meip_end, bus.mtip_end,
                             bus.flush, bus.wfi_halt, bus.in_handler}, 32'd0);
    check_eq("rst_cnt", {16'd0, bus.taken_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: external take latency and single-cycle pulse
    bus.mie = 1'b1; bus.meie = 1'b1; bus.mtie = 1'b1;
    exp_q.push_back(E_EN);
    bus.dma_irq = 1'b1;
    repeat (2) tick();
    check_eq("t1_en_early", {31'd0, bus.meip_en}, 32'd0);
    tick();
    check_eq("t1_en_at3", {31'd0, bus.meip_en}, 32'd1);
    check_eq("t1_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    exp_cnt = 16'd1; exp_small = 2'd1;
    check_eq("t1_en_off", {31'd0, bus.meip_en}, 32'd0);
    check_eq("t1_cnt", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
    bus.dma_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(E_END);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    check_eq("t1_end", {31'd0, bus.meip_end}, 32'd1);
    tick();
    check_eq("t1_end_off", {31'd0, bus.meip_end}, 32'd0);
    check_eq("t1_idle", {31'd0, bus.in_handler}, 32'd0);

    // 2: simultaneous requests, external wins, timer re-takes after return
    exp_q.push_back(E_EN);
    bus.dma_irq = 1'b1; bus.wdt_irq = 1'b1;
    repeat (3) tick();
    check_eq("t2_e_wins", {30'd0, bus.meip_en, bus.mtip_en}, 32'd2);
    tick();
    bus.dma_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(E_END);
    exp_q.push_back(T_EN);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    repeat (2) tick();
    check_eq("t2_t_retake", {31'd0, bus.mtip_en}, 32'd1);
    tick();
    bus.wdt_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(T_END);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    tick();
    exp_cnt = 16'd3; exp_small = 2'd3;
    check_eq("t2_cnt", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});

    // 3: stalled take holds the pulse, one count added
    for (int i = 0; i < 5; i++) exp_q.push_back(T_EN);
    bus.wdt_irq = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_held", {31'd0, bus.mtip_en}, 32'd1);
      tick();
    end
    bus.stall = 1'b0;
    check_eq("t3_unstalled", {31'd0, bus.mtip_en}, 32'd1);
    check_eq("t3_cnt_hold", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
    tick();
    exp_cnt = 16'd4;
    check_eq("t3_exit", {31'd0, bus.mtip_en}, 32'd0);
    check_eq("t3_cnt", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
    bus.wdt_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(T_END);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    tick();

    // 4: WFI with MIE clear wakes on pending timer without taking it
    bus.mie = 1'b0;
    bus.wfi_in = 1'b1;
    tick();
    check_eq("t4_halt_set", {31'd0, bus.wfi_halt}, 32'd1);
    bus.wfi_in = 1'b0;
    bus.wdt_irq = 1'b1;
    repeat (2) tick();
    check_eq("t4_halt_hold", {31'd0, bus.wfi_halt}, 32'd1);
    tick();
    check_eq("t4_halt_clr", {31'd0, bus.wfi_halt}, 32'd0);
    repeat (3) tick();
    check_eq("t4_no_take", {30'd0, bus.mtip_en, bus.in_handler}, 32'd0);
    bus.wdt_irq = 1'b0;
    repeat (3) tick();

    // 5: no nesting, and MRET in IDLE gives no end pulse
    bus.mie = 1'b1;
    exp_q.push_back(E_EN);
    bus.dma_irq = 1'b1;
    repeat (4) tick();
    bus.wdt_irq = 1'b1;
    repeat (5) tick();
    check_eq("t5_in_handler", {31'd0, bus.in_handler}, 32'd1);
    bus.dma_irq = 1'b0;
    exp_q.push_back(E_END);
    exp_q.push_back(T_EN);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    repeat (2) tick();
    check_eq("t5_t_after_ret", {31'd0, bus.mtip_en}, 32'd1);
    tick();
    bus.wdt_irq = 1'b0;
    repeat (2) tick();
    exp_q.push_back(T_END);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    tick();
    exp_cnt = 16'd6;
    check_eq("t5_cnt", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
    bus.mret_in = 1'b1;
    repeat (2) tick();
    bus.mret_in = 1'b0;
    check_eq("t5_idle_mret", {29'd0, bus.meip_end, bus.mtip_end, bus.in_handler}, 32'd0);

    // 6: reset inside handler aborts without end pulse; small counter saturates
    exp_q.push_back(E_EN);
    bus.dma_irq = 1'b1;
    repeat (4) tick();
    check_eq("t6_in_handler", {31'd0, bus.in_handler}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_async", {25'd0, bus.meip_en, bus.mtip_en, bus.meip_end, bus.mtip_end,
                              bus.flush, bus.wfi_halt, bus.in_handler}, 32'd0);
    bus.dma_irq = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_cnt = 16'd0; exp_small = 2'd0;
    check_eq("t6_cnt_rst", {16'd0, bus.taken_cnt}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) take_and_return(i[0]);
    check_eq("t6_cnt", {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
    check_eq("t6_cnt_sat", {30'd0, bus2.taken_cnt}, {30'd0, exp_small});
    repeat (3) tick();

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
